mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 14; word-index width driven to the data RAM.
REQ-002 Parameter BASE_HI, default 16'h1000; required value of addr[31:16] for an in-range access.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 p0_req, p1_req  input  1 each  request valid; port 0 = CPU load/store, port 1 = DMA/loader.
REQ-006 p0_we, p1_we  input  4 each  byte write mask; 4'b0000 means read.
REQ-007 p0_addr, p1_addr  input  32 each  byte address.
REQ-008 p0_wdata, p1_wdata  input  32 each  write data.
REQ-009 p0_gnt, p1_gnt  output  1 each  request accepted this cycle (combinational).
REQ-010 p0_rvalid, p1_rvalid  output  1 each  read data/response valid (one-cycle pulse).
REQ-011 p0_rdata, p1_rdata  output  32 each  read data; qualified by the matching rvalid.
REQ-012 p0_err, p1_err  output  1 each  out-of-range response (one-cycle pulse).
REQ-013 mem_en  output  1  data RAM enable.
REQ-014 mem_we  output  4  data RAM byte write enables.
REQ-015 mem_addr  output  ADDR_BITS  word address, equal to addr[ADDR_BITS+1:2] of the granted request.
REQ-016 mem_din  output  32  write data of the granted request.
REQ-017 mem_dout  input  32  RAM read data, valid exactly one cycle after the read is issued.

Function
REQ-018 At most one of p0_gnt/p1_gnt shall be high in any cycle; a grant is given only to a requesting port.
REQ-019 A single requester shall be granted in the same cycle it requests, with no bubbles for back-to-back requests.
REQ-020 Both requesting: round-robin arbitration; grant the port not granted most recently; the 1-bit last_grant register updates on every grant.
REQ-021 In-range (addr[31:16]==BASE_HI) granted request: mem_en=1, mem_we=req we, mem_addr/mem_din from the granted port, all in the grant cycle.
REQ-022 Out-of-range granted request: mem_en=0, mem_we=0; no RAM access.
REQ-023 Cycles with no grant: mem_en=0, mem_we=0; mem_addr/mem_din don't-care.
REQ-024 Response pipeline: one registered stage holding {valid, port, is_read, err}, loaded every cycle.
REQ-025 In-range read granted in cycle N: the owning port's rvalid=1 in cycle N+1, with rdata=mem_dout.
REQ-026 In-range write: gnt is the only acknowledgement; no rvalid and no err.
REQ-027 Out-of-range request (read or write) granted in cycle N: the owning port's err=1 in cycle N+1.
REQ-028 Out-of-range request, additionally for reads: rvalid=1 and rdata=32'h0 in cycle N+1.
REQ-029 rdata of a port not in a read response shall be 32'h0; rvalid/err never assert on the non-owning port.
REQ-030 Responses for back-to-back grants appear in consecutive cycles, in grant order, each routed to its own port.
REQ-031 Requests with unaligned addresses use addr[1:0] only through the mask; no realignment in this block.

Reset
REQ-032 While rst=1: both gnt=0, both rvalid=0, both err=0, mem_en=0, mem_we=0, rdata=0.
REQ-033 While rst=1: last_grant resets so port 0 wins the first contention after reset.
REQ-034 Reset in the cycle after a read grant shall discard that response; no rvalid in or after the reset cycle.
REQ-035 The first grant is possible in the first cycle with rst=0.

Verification
REQ-036 p0 read addr 32'h1000_0010, RAM word 4 = 32'hDEADBEEF -> cycle N: p0_gnt=1, mem_addr=4, mem_we=0; cycle N+1: p0_rvalid=1, p0_rdata=32'hDEADBEEF.
REQ-037 p1 write addr 32'h1000_0008, we=4'b0011, wdata=32'h0000_ABCD -> same cycle: p1_gnt=1, mem_en=1, mem_we=4'b0011, mem_addr=2; no rvalid or err follows.
REQ-038 Both ports request continuously for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1; responses alternate one cycle later.
REQ-039 p0 read addr 32'h2000_0000 -> p0_gnt=1 and mem_en=0; next cycle p0_rvalid=1, p0_err=1, p0_rdata=0.
REQ-040 p0 read granted, then rst=1 on the next cycle -> p0_rvalid stays 0; after rst drops, contention grants p0 first.
REQ-041 Random mixed traffic on both ports over 10k cycles against a RAM model -> every read returns the last value written to its word, with no grant overlap.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 14
);
    logic                 p0_req;
    logic                 p1_req;
    logic [3:0]           p0_we;
    logic [3:0]           p1_we;
    logic [31:0]          p0_addr;
    logic [31:0]          p1_addr;
    logic [31:0]          p0_wdata;
    logic [31:0]          p1_wdata;
    logic                 p0_gnt;
    logic                 p1_gnt;
    logic                 p0_rvalid;
    logic                 p1_rvalid;
    logic [31:0]          p0_rdata;
    logic [31:0]          p1_rdata;
    logic                 p0_err;
    logic                 p1_err;
    logic                 mem_en;
    logic [3:0]           mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_din;
    logic [31:0]          mem_dout;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_dout,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
               p0_err, p1_err, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_dout,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
               p0_err, p1_err, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data RAM with a
// one-stage response pipeline that routes read data and range errors back.
module mem_arbiter #(
    parameter int          ADDR_BITS = 14,
    parameter logic [15:0] BASE_HI   = 16'h1000
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    // last_grant_q = 1 means port 1 was granted most recently, so port 0 wins next contention
    logic        last_grant_q, last_grant_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_port_q, resp_port_d;
    logic        resp_read_q, resp_read_d;
    logic        resp_err_q, resp_err_d;

    logic        gnt0_s, gnt1_s, any_gnt_s, sel_s, in_range_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [3:0]  sel_we_s;
    logic        hit0_s, hit1_s;
    logic        unused_addr_s;

    // Round-robin grant decision
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.p0_req && bus.p1_req) begin
            if (last_grant_q) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.p0_req) begin
            gnt0_s = 1'b1;
        end else if (bus.p1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Granted-request mux and RAM drive
    always_comb begin
        any_gnt_s = gnt0_s | gnt1_s;
        sel_s     = gnt1_s;
        if (sel_s) begin
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
            sel_we_s    = bus.p1_we;
        end else begin
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
            sel_we_s    = bus.p0_we;
        end
        in_range_s   = (sel_addr_s[31:16] == BASE_HI);
        bus.mem_en   = any_gnt_s & in_range_s;
        bus.mem_we   = bus.mem_en ? sel_we_s : 4'b0000;
        bus.mem_addr = sel_addr_s[ADDR_BITS+1:2];
        bus.mem_din  = sel_wdata_s;
        bus.p0_gnt   = gnt0_s;
        bus.p1_gnt   = gnt1_s;
    end

    // Byte lanes below the word index and the high half reach the RAM only indirectly
    assign unused_addr_s = ^sel_addr_s;

    // Next state of the arbitration pointer and the response stage
    always_comb begin
        last_grant_d = any_gnt_s ? sel_s : last_grant_q;
        resp_valid_d = any_gnt_s;
        resp_port_d  = sel_s;
        resp_read_d  = (sel_we_s == 4'b0000);
        resp_err_d   = ~in_range_s;
    end

    // State registers; reset hands the first contention to port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_read_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_read_q  <= resp_read_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Response routing; rst masks a response still sitting in the stage
    always_comb begin
        hit0_s        = resp_valid_q & ~rst & ~resp_port_q;
        hit1_s        = resp_valid_q & ~rst & resp_port_q;
        bus.p0_rvalid = hit0_s & resp_read_q;
        bus.p1_rvalid = hit1_s & resp_read_q;
        bus.p0_err    = hit0_s & resp_err_q;
        bus.p1_err    = hit1_s & resp_err_q;
        if (bus.p0_rvalid && !resp_err_q) begin
            bus.p0_rdata = bus.mem_dout;
        end else begin
            bus.p0_rdata = 32'h0000_0000;
        end
        if (bus.p1_rvalid && !resp_err_q) begin
            bus.p1_rdata = bus.mem_dout;
        end else begin
            bus.p1_rdata = 32'h0000_0000;
        end
    end
endmodule
